a51_ctrl: RTL and testbench

- Sequencing controller for the A5/1 keystream core. Sits directly upstream of the three LFSR stages (19/22/23-bit, each with shift_bit/trigger inputs).
- Latches a 64-bit session key and a 22-bit frame number, then clears the LFSRs.
- Serially loads key then frame into all three LFSRs, runs the mixing phase with majority clocking, then runs the keystream phase.
- During the keystream phase it flags each cycle where the LFSR output XOR is a valid keystream bit.

---
 rtl/a51_ctrl_if.sv | 39 +++
 rtl/a51_ctrl.sv | 142 ++++++++++++++
 tb/tb_a51_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/a51_ctrl_if.sv
// rtl/a51_ctrl_if.sv - A5/1 controller bus bundle; A51_KS_READY_EN adds ks_ready
interface a51_ctrl_if #(
    parameter int KEY_LEN   = 64,
    parameter int FRAME_LEN = 22
);
    logic                 start;
    logic [KEY_LEN-1:0]   key;
    logic [FRAME_LEN-1:0] frame;
    logic                 r1_cb;
    logic                 r2_cb;
    logic                 r3_cb;
`ifdef A51_KS_READY_EN
    logic                 ks_ready;
`endif
    logic                 lfsr_clear;
    logic                 shift_bit;
    logic                 trig1;
    logic                 trig2;
    logic                 trig3;
    logic                 busy;
    logic                 ks_valid;
    logic                 done;

    modport master (
`ifdef A51_KS_READY_EN
        output ks_ready,
`endif
        output start, key, frame, r1_cb, r2_cb, r3_cb,
        input  lfsr_clear, shift_bit, trig1, trig2, trig3, busy, ks_valid, done
    );

    modport slave (
`ifdef A51_KS_READY_EN
        input  ks_ready,
`endif
        input  start, key, frame, r1_cb, r2_cb, r3_cb,
        output lfsr_clear, shift_bit, trig1, trig2, trig3, busy, ks_valid, done
    );
endinterface

// File: rtl/a51_ctrl.sv
// rtl/a51_ctrl.sv - A5/1 LFSR sequencer: clear, key/frame load, mix, keystream
// Optional A51_KS_READY_EN: ks_ready stalls the keystream phase.
module a51_ctrl #(
    parameter int KEY_LEN    = 64,
    parameter int FRAME_LEN  = 22,
    parameter int MIX_CYCLES = 100,
    parameter int KS_LEN     = 228,
    parameter int CNT_W      = 8
) (
    input  logic     clk,
    input  logic     reset,
    a51_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD_KEY, S_LOAD_FRAME, S_MIX, S_KS, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_LEN - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [KEY_LEN-1:0]   key_q, key_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic                 ks_valid_q, ks_valid_d;

    logic       maj;
    logic [2:0] maj_trig;
    logic [2:0] trig;
    logic       ks_adv;
    logic       lfsr_clear;
    logic       shift_bit;
    logic       done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            key_q      <= '0;
            frame_q    <= '0;
            ks_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            frame_q    <= frame_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    // Triggers depend only on registered LFSR bits, so no combinational loop.
    assign maj      = (bus.r1_cb & bus.r2_cb) | (bus.r1_cb & bus.r3_cb) | (bus.r2_cb & bus.r3_cb);
    assign maj_trig = {bus.r1_cb == maj, bus.r2_cb == maj, bus.r3_cb == maj};

`ifdef A51_KS_READY_EN
    assign ks_adv = bus.ks_ready;
`else
    assign ks_adv = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        key_d      = key_q;
        frame_d    = frame_q;
        ks_valid_d = 1'b0;
        lfsr_clear = 1'b0;
        shift_bit  = 1'b0;
        trig       = 3'b000;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = S_CLEAR;
                    key_d   = bus.key;
                    frame_d = bus.frame;
                end
            end
            S_CLEAR: begin
                lfsr_clear = 1'b1;
                cnt_d      = '0;
                state_d    = S_LOAD_KEY;
            end
            S_LOAD_KEY: begin
                trig      = 3'b111;
                shift_bit = |(key_q & (KEY_LEN'(1) << cnt_q));
                if (cnt_q == KEY_LAST) begin
                    state_d = S_LOAD_FRAME;
                    cnt_d   = '0;
                end
            end
            S_LOAD_FRAME: begin
                trig      = 3'b111;
                shift_bit = |(frame_q & (FRAME_LEN'(1) << cnt_q));
                if (cnt_q == FRAME_LAST) begin
                    state_d = S_MIX;
                    cnt_d   = '0;
                end
            end
            S_MIX: begin
                trig = maj_trig;
                if (cnt_q == MIX_LAST) begin
                    state_d = S_KS;
                    cnt_d   = '0;
                end
            end
            S_KS: begin
                if (ks_adv) begin
                    trig       = maj_trig;
                    ks_valid_d = 1'b1;
                    if (cnt_q == KS_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.lfsr_clear = lfsr_clear;
    assign bus.shift_bit  = shift_bit;
    assign bus.trig1      = trig[2];
    assign bus.trig2      = trig[1];
    assign bus.trig3      = trig[0];
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.ks_valid   = ks_valid_q;
    assign bus.done       = done;
endmodule

// File: tb/tb_a51_ctrl.sv
// tb/tb_a51_ctrl.sv - directed bench for a51_ctrl with behavioural A5/1 LFSRs
`timescale 1ns/1ps
module tb_a51_ctrl;
    localparam logic [63:0] KEY_A   = 64'h0123456789ABCDEF;
    localparam logic [21:0] FRAME_A = 22'h134;
`ifdef A51_KS_READY_EN
    localparam int STALL = 10;
`else
    localparam int STALL = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    a51_ctrl_if #(.KEY_LEN(64), .FRAME_LEN(22)) bus ();
    a51_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic        force_cb = 1'b0;
    logic [2:0]  fcb = 3'b000;
    wire         lfsr_rst = reset | bus.lfsr_clear;
    wire [7:0]   outs = {bus.busy, bus.lfsr_clear, bus.shift_bit, bus.trig1,
                         bus.trig2, bus.trig3, bus.ks_valid, bus.done};
    wire [2:0]   trigs = {bus.trig1, bus.trig2, bus.trig3};

    always @(posedge clk) begin
        if (lfsr_rst) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else begin
            if (bus.trig1) r1 <= {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ bus.shift_bit};
            if (bus.trig2) r2 <= {r2[20:0], r2[20] ^ r2[21] ^ bus.shift_bit};
            if (bus.trig3) r3 <= {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ bus.shift_bit};
        end
    end

    always_comb begin
        bus.r1_cb = force_cb ? fcb[2] : r1[8];
        bus.r2_cb = force_cb ? fcb[1] : r2[10];
        bus.r3_cb = force_cb ? fcb[0] : r3[10];
    end

    function automatic logic [227:0] a51_ref(input logic [63:0] k, input logic [21:0] f);
        logic [18:0]  a;
        logic [21:0]  b;
        logic [22:0]  c;
        logic [63:0]  kk;
        logic [21:0]  ff;
        logic [227:0] ks;
        logic         bi;
        logic         m;
        a = '0; b = '0; c = '0; kk = k; ff = f; ks = '0;
        for (int i = 0; i < 86; i++) begin
            if (i < 64) begin
                bi = kk[0];
                kk = kk >> 1;
            end else begin
                bi = ff[0];
                ff = ff >> 1;
            end
            a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18] ^ bi};
            b = {b[20:0], b[20] ^ b[21] ^ bi};
            c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22] ^ bi};
        end
        for (int i = 0; i < 328; i++) begin
            m = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
            if (a[8] == m)  a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18]};
            if (b[10] == m) b = {b[20:0], b[20] ^ b[21]};
            if (c[10] == m) c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22]};
            if (i >= 100) ks = {a[18] ^ b[21] ^ c[22], ks[227:1]};
        end
        return ks;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int           cyc;
    int           ntrig;
    int           nks;
    int           busy_drops;
    int           done_cyc;
    logic [63:0]  kbits;
    logic [21:0]  fbits;
    logic [227:0] kscol;
    logic [227:0] ks_exp;

    initial begin
        bus.start = 1'b1;
        bus.key   = KEY_A;
        bus.frame = FRAME_A;
`ifdef A51_KS_READY_EN
        bus.ks_ready = 1'b1;
`endif
        // start held through reset is not taken until the first edge after release
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {56'd0, outs}, 64'd0);
        reset = 1'b0;
        #1;
        chk("release_idle", {56'd0, outs}, 64'd0);
        tick;
        chk("release_accept", {62'd0, bus.busy, bus.lfsr_clear}, 64'd3);
        bus.start = 1'b0;
        repeat (29) tick;
        chk("load_key_trig", {61'd0, trigs}, 64'd7);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outs", {56'd0, outs}, 64'd0);
        repeat (2) tick;
        reset = 1'b0;
        tick;
        chk("idle_after_reset", {56'd0, outs}, 64'd0);

        // full run with live LFSRs
        bus.key   = KEY_A;
        bus.frame = FRAME_A;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc = 1;
        chk("clear_outs", {56'd0, outs}, 64'hC0);
        bus.key   = ~KEY_A;
        bus.frame = ~FRAME_A;
        kbits = '0; fbits = '0; kscol = '0;
        ntrig = 0; nks = 0; busy_drops = 0; done_cyc = 0;
        while (cyc < 1000) begin
            tick;
            cyc++;
            if (cyc >= 2 && cyc <= 65) kbits = {bus.shift_bit, kbits[63:1]};
            if (cyc >= 66 && cyc <= 87) fbits = {bus.shift_bit, fbits[21:1]};
            if (cyc >= 2 && cyc <= 87 && trigs == 3'b111) ntrig++;
            if (bus.ks_valid) begin
                kscol = {r1[18] ^ r2[21] ^ r3[22], kscol[227:1]};
                nks++;
            end
            if (!bus.busy) busy_drops++;
            bus.start = (cyc == 50);
`ifdef A51_KS_READY_EN
            if (cyc == 193) bus.ks_ready = 1'b0;
            if (cyc == 203) bus.ks_ready = 1'b1;
`endif
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
        end
        ks_exp = a51_ref(KEY_A, FRAME_A);
        chk("key_first8", {56'd0, kbits[7:0]}, 64'hEF);
        chk("key_all", kbits, KEY_A);
        chk("frame_first10", {54'd0, fbits[9:0]}, 64'h134);
        chk("frame_all", {42'd0, fbits}, {42'd0, FRAME_A});
        chk("load_trig_count", 64'(ntrig), 64'd86);
        chk("busy_drops", 64'(busy_drops), 64'd0);
        chk("done_cycle", 64'(done_cyc), 64'(416 + STALL));
        chk("ks_count", 64'(nks), 64'd228);
        checks++;
        assert (kscol === ks_exp) else begin
            errors++;
            $error("FAIL ks_bits observed=%0h expected=%0h", kscol, ks_exp);
        end

        // start during DONE is dropped, taken the cycle after
        bus.start = 1'b1;
        bus.key   = 64'hFEDCBA9876543210;
        bus.frame = 22'h2AAAA;
        tick;
        chk("done_start_ignored", {56'd0, outs}, 64'd0);
        tick;
        chk("accept_after_done", {56'd0, outs}, 64'hC0);
        bus.start = 1'b0;
        repeat (87) tick;
        force_cb = 1'b1;
        fcb = 3'b101;
        #1;
        chk("maj_101", {61'd0, trigs}, 64'd5);
        fcb = 3'b000;
        #1;
        chk("maj_000", {61'd0, trigs}, 64'd7);
        fcb = 3'b011;
        #1;
        chk("maj_011", {61'd0, trigs}, 64'd3);
        chk("mix_shift_busy", {62'd0, bus.busy, bus.shift_bit}, 64'd2);
        reset = 1'b1;
        #1;
        chk("final_reset", {56'd0, outs}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
